// File: rtl/mov_seq_pkg.sv
// mov_seq_pkg: shared types and constants for the constant decomposer.
//   state_t      - FSM states (IDLE, EMIT)
//   MOV_TYPE_*   - mov_type encoding shared with the MOVZ/MOVK calculator
//   mov_op_t     - one emitted operation {rd, imm16, shamt, mov_type, last}
//   build_mask   - pending-halfword mask for a freshly accepted constant
// Optional feature macro: MOVSEQ_ZERO_SKIP_EN (skip all-zero halfwords).
package mov_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic MOV_TYPE_MOVK = 1'b0;
    localparam logic MOV_TYPE_MOVZ = 1'b1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [15:0] imm16;
        logic [1:0]  shamt;
        logic        mov_type;
        logic        last;
    } mov_op_t;

`ifdef MOVSEQ_ZERO_SKIP_EN
    localparam logic KEEP_ZERO_HW = 1'b0;
`else
    localparam logic KEEP_ZERO_HW = 1'b1;
`endif

    // Bit h marks halfword h as still to be emitted. Zero halfwords are only
    // dropped in the skip build; an all-zero constant still needs one MOVZ #0.
    function automatic logic [3:0] build_mask(input logic [63:0] value);
        logic [3:0] m;
        for (int h = 0; h < 4; h++) begin
            m[h] = (|value[16*h +: 16]) | KEEP_ZERO_HW;
        end
        if (m == 4'b0000) begin
            m = 4'b0001;
        end
        return m;
    endfunction

endpackage

// File: rtl/mov_seq_if.sv
// mov_seq_if: command (in_*) and operation (out_*) handshake bundle.
//   master - constant source / op consumer side (testbench, expander)
//   slave  - mov_seq side
interface mov_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_value;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [15:0] out_imm16;
    logic [1:0]  out_shamt;
    logic        out_mov_type;
    logic        out_last;

    modport master (
        output in_valid, in_value, in_rd, out_ready,
        input  in_ready, out_valid, out_rd, out_imm16, out_shamt,
               out_mov_type, out_last
    );

    modport slave (
        input  in_valid, in_value, in_rd, out_ready,
        output in_ready, out_valid, out_rd, out_imm16, out_shamt,
               out_mov_type, out_last
    );
endinterface

// File: rtl/mov_seq_hw_pick.sv
// mov_hw_pick: combinational lowest-set-bit picker over the pending mask.
//   mask   in  4  pending halfwords
//   idx    out 2  index of the lowest set bit (0 when mask is empty)
//   clr    out 4  one-hot of that bit (all zero when mask is empty)
//   single out 1  exactly one bit of mask is set
module mov_hw_pick (
    input  logic [3:0] mask,
    output logic [1:0] idx,
    output logic [3:0] clr,
    output logic       single
);
    // A bit wins when it is set and nothing below it is set.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pick
            if (gi == 0) begin : g_lsb
                assign clr[gi] = mask[gi];
            end else begin : g_upper
                assign clr[gi] = mask[gi] & ~(|mask[gi-1:0]);
            end
        end
    endgenerate

    assign idx    = {clr[3] | clr[2], clr[3] | clr[1]};
    assign single = (mask != 4'b0000) && ((mask & (mask - 4'd1)) == 4'b0000);
endmodule

// File: rtl/mov_seq.sv
// mov_seq: splits a 64-bit constant into MOVZ + MOVK operations for rd.
//   clk      in  rising-edge clock
//   reset_n  in  asynchronous active-low reset
//   bus      slave modport of mov_seq_if (in_* command, out_* operation)
// Outputs are decoded from registered state only.
// Optional feature macro: MOVSEQ_ZERO_SKIP_EN (see mov_seq_pkg).
module mov_seq
    import mov_seq_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    mov_seq_if.slave bus
);
    state_t      state_reg;
    logic [63:0] value_reg;
    logic [4:0]  rd_reg;
    logic [3:0]  mask_reg;
    logic        first_reg;

    logic [15:0] hw [4];
    logic [1:0]  pick_idx;
    logic [3:0]  pick_clr;
    logic        pick_single;
    mov_op_t     cur_op;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_hw
            assign hw[gi] = value_reg[16*gi +: 16];
        end
    endgenerate

    mov_hw_pick u_pick (
        .mask   (mask_reg),
        .idx    (pick_idx),
        .clr    (pick_clr),
        .single (pick_single)
    );

    // Operation fields read as zero outside EMIT so an idle block shows a
    // clean bus rather than leftovers of the previous command.
    always_comb begin
        cur_op = '0;
        if (state_reg == EMIT) begin
            cur_op.rd       = rd_reg;
            cur_op.imm16    = hw[pick_idx];
            cur_op.shamt    = pick_idx;
            cur_op.mov_type = first_reg ? MOV_TYPE_MOVZ : MOV_TYPE_MOVK;
            cur_op.last     = pick_single;
        end
    end

    assign bus.in_ready     = (state_reg == IDLE);
    assign bus.out_valid    = (state_reg == EMIT);
    assign bus.out_rd       = cur_op.rd;
    assign bus.out_imm16    = cur_op.imm16;
    assign bus.out_shamt    = cur_op.shamt;
    assign bus.out_mov_type = cur_op.mov_type;
    assign bus.out_last     = cur_op.last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            value_reg <= '0;
            rd_reg    <= '0;
            mask_reg  <= '0;
            first_reg <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        value_reg <= bus.in_value;
                        rd_reg    <= bus.in_rd;
                        mask_reg  <= build_mask(bus.in_value);
                        first_reg <= 1'b1;
                        state_reg <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        mask_reg  <= mask_reg & ~pick_clr;
                        first_reg <= 1'b0;
                        // Last op leaves mask empty; the next command can
                        // only be taken from IDLE, never overlapped.
                        if (pick_single) begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mov_seq.sv
// tb_mov_seq: randomized and directed bench for mov_seq with a queue-based
// reference model of the operation stream.
module tb_mov_seq;
    import mov_seq_pkg::*;

`ifdef MOVSEQ_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk;
    logic reset_n;
    mov_seq_if bus_if ();

    mov_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: expected operation list of the command in flight.
    mov_op_t m_q[$];
    bit      m_busy;
    mov_op_t cap[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_accept(input logic [63:0] v, input logic [4:0] r);
        mov_op_t op;
        m_q.delete();
        for (int h = 0; h < 4; h++) begin
            if (!SKIP || v[16*h +: 16] != 16'h0) begin
                op = '0;
                op.rd = r;
                op.imm16 = v[16*h +: 16];
                op.shamt = 2'(h);
                m_q.push_back(op);
            end
        end
        if (m_q.size() == 0) begin
            op = '0;
            op.rd = r;
            m_q.push_back(op);
        end
        m_q[0].mov_type = 1'b1;
        m_q[m_q.size()-1].last = 1'b1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (bus_if.out_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_busy = 1'b0;
            end
        end else if (bus_if.in_valid) begin
            model_accept(bus_if.in_value, bus_if.in_rd);
            m_busy = 1'b1;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        mov_op_t got;
        if (chk_en && reset_n) begin
            got = {bus_if.out_rd, bus_if.out_imm16, bus_if.out_shamt,
                   bus_if.out_mov_type, bus_if.out_last};
            check("in_ready", 64'(bus_if.in_ready), 64'(!m_busy));
            check("out_valid", 64'(bus_if.out_valid), 64'(m_busy));
            if (m_busy && m_q.size() > 0) begin
                check("op_fields", 64'(got), 64'(m_q[0]));
            end
            if (bus_if.out_valid && bus_if.out_ready) cap.push_back(got);
        end
    end

    task automatic chk_op(input string name, input int idx, input logic [4:0] rd,
                          input logic [15:0] imm, input logic [1:0] sh,
                          input logic mt, input logic last);
        mov_op_t g;
        mov_op_t e;
        g = (idx < cap.size()) ? cap[idx] : '0;
        e = {rd, imm, sh, mt, last};
        check(name, 64'(g), 64'(e));
    endtask

    // Called at #1 after a rising edge while idle; returns at the same phase.
    task automatic run_cmd(input logic [63:0] v, input logic [4:0] r,
                           input int stall, input bit rnd);
        int cyc;
        int waited;
        logic [63:0] recon;
        cap.delete();
        in_drive(1'b1, v, r);
        bus_if.out_ready = 1'b0;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        cyc = 0;
        waited = 0;
        while (m_busy && cyc < 200) begin
            if (rnd) begin
                bus_if.out_ready = ($urandom_range(0, 3) != 0);
                in_drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, 5'($urandom));
            end else begin
                bus_if.out_ready = (waited >= stall);
            end
            @(posedge clk); #1;
            cyc++;
            if (bus_if.out_ready) waited = 0; else waited++;
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        if (cyc >= 200) check("cmd_timeout", 64'(cyc), 64'(0));
        // Replay through MOVZ/MOVK semantics and check the constant returns.
        recon = '0;
        for (int i = 0; i < cap.size(); i++) begin
            if (cap[i].mov_type) recon = 64'(cap[i].imm16) << (16 * cap[i].shamt);
            else recon[16*cap[i].shamt +: 16] = cap[i].imm16;
            check("replay_type", 64'(cap[i].mov_type), 64'(i == 0));
            check("replay_last", 64'(cap[i].last), 64'(i == cap.size() - 1));
            check("replay_rd", 64'(cap[i].rd), 64'(r));
        end
        check("replay_value", recon, v);
    endtask

    task automatic in_drive(input logic vld, input logic [63:0] v, input logic [4:0] r);
        bus_if.in_valid = vld;
        bus_if.in_value = v;
        bus_if.in_rd    = r;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] v;
        reset_n = 1'b0;
        in_drive(1'b0, 64'h0, 5'h0);
        bus_if.out_ready = 1'b0;
        #3;
        check("reset_outs", {bus_if.out_valid, bus_if.out_rd, bus_if.out_imm16,
              bus_if.out_shamt, bus_if.out_mov_type, bus_if.out_last}, 64'h0);
        #19 reset_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        check("ready_after_reset", 64'(bus_if.in_ready), 64'h1);

        run_cmd(64'h0000_0000_0000_0000, 5'd3, 0, 1'b0);
        check("zero_nops", 64'(cap.size()), SKIP ? 64'd1 : 64'd4);
        chk_op("zero_op0", 0, 5'd3, 16'h0, 2'd0, 1'b1, SKIP);

        run_cmd(64'h1234_0000_0000_5678, 5'd7, 0, 1'b0);
        check("two_nops", 64'(cap.size()), SKIP ? 64'd2 : 64'd4);
        chk_op("two_op0", 0, 5'd7, 16'h5678, 2'd0, 1'b1, 1'b0);
        chk_op("two_op1", 1, 5'd7, SKIP ? 16'h1234 : 16'h0, SKIP ? 2'd3 : 2'd1, 1'b0, SKIP);
        chk_op("two_oplast", SKIP ? 1 : 3, 5'd7, 16'h1234, 2'd3, 1'b0, 1'b1);

        run_cmd(64'h0000_BEEF_0000_0000, 5'd12, 0, 1'b0);
        check("beef_nops", 64'(cap.size()), SKIP ? 64'd1 : 64'd4);
        chk_op("beef_op", SKIP ? 0 : 2, 5'd12, 16'hBEEF, 2'd2, SKIP, SKIP);

        run_cmd(64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 3, 1'b0);
        check("ones_nops", 64'(cap.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk_op("ones_op", i, 5'd31, 16'hFFFF, 2'(i), i == 0, i == 3);
        end

        // Reset in the middle of a command after two handshakes.
        cap.delete();
        in_drive(1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 5'd9);
        @(posedge clk); #1;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        bus_if.out_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        check("midreset_outs", {bus_if.out_valid, bus_if.out_rd, bus_if.out_imm16,
              bus_if.out_shamt, bus_if.out_mov_type, bus_if.out_last}, 64'h0);
        check("midreset_ops", 64'(cap.size()), 64'd2);
        #2 reset_n = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        check("midreset_ready", 64'(bus_if.in_ready), 64'h1);
        check("midreset_noresume", 64'(cap.size()), 64'd2);

        for (int n = 0; n < 40; n++) begin
            for (int h = 0; h < 4; h++) begin
                v[16*h +: 16] = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
            end
            run_cmd(v, 5'($urandom), 0, 1'b1);
            if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mov_seq.md
# mov_seq

Sequential constant decomposer for the datapath's immediate-load path. It accepts a 64-bit constant and a destination register, then emits a MOVZ followed by zero or more MOVK operations (imm16, shamt, mov_type), one per handshake. Replaying these operations through the MOVZ/MOVK calculator in order rebuilds the original constant in Rd. It sits between the constant/literal source (assembler test harness or micro-op expander) and the execute stage.

## Interface
- No parameters. Widths are fixed: 64-bit data, 16-bit halfwords, 5-bit register index.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  command valid.
- in_ready  out  1  block can accept a command.
- in_value  in  64  constant to materialise.
- in_rd  in  5  destination register.
- out_valid  out  1  operation valid.
- out_ready  in  1  consumer accepts the operation.
- out_rd  out  5  destination register of the operation.
- out_imm16  out  16  halfword immediate.
- out_shamt  out  2  halfword position (shift = 16 × shamt).
- out_mov_type  out  1  0 = MOVK, 1 = MOVZ.
- out_last  out  1  final operation of the current command.

## Operation
- FSM states are IDLE and EMIT.
  - IDLE: in_ready=1, out_valid=0.
  - EMIT: in_ready=0, out_valid=1.
- Command accept: an in_valid & in_ready handshake in IDLE.
  - Latches in_value and in_rd.
  - Builds a 4-bit pending mask, where bit h = (in_value[16h+15:16h] != 0).
  - Sets first=1 and moves to EMIT.
- All-zero value: if in_value==0, the mask is forced to 4'b0001. The result is a single MOVZ #0, shamt 0.
- Current operation: h is the lowest set bit of the pending mask.
  - out_imm16 = value halfword h.
  - out_shamt = h.
  - out_mov_type = first.
  - out_last = (exactly one mask bit set).
- Operation handshake: out_valid & out_ready clears mask bit h and sets first=0.
  - If out_last was 1, the FSM returns to IDLE.
- Ordering: MOVZ is always first, then MOVKs in ascending halfword order. One command produces 1 to 4 operations.
- Stall: while out_valid=1 and out_ready=0, all out_* signals hold stable.
- Inputs are ignored while in EMIT (in_ready=0). A new command is not overlapped with the last operation of the previous one.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE.
  - in_ready=1 once reset is released.
  - out_valid=0, out_rd=0, out_imm16=0, out_shamt=0, out_mov_type=0, out_last=0.
  - Mask, first and latched value are cleared.
- Reset mid-command aborts it. The remaining operations are discarded and never emitted.
- Latency: a command accepted at edge N presents its first operation (out_valid=1) after edge N. Each further operation appears on the edge following the previous handshake.
- After the out_last handshake at edge M, in_ready=1 after edge M. Throughput is (ops + 1) cycles per command when out_ready is held high.
- All outputs are registered or decoded from registered state only. There is no combinational path from in_* or out_ready to any output.

## Configuration
- Macro: MOVSEQ_ZERO_SKIP_EN.
- Defined: zero halfwords are skipped as described under Operation, giving 1 to 4 operations per command.
- Undefined: the mask is always 4'b1111. Every command emits exactly 4 operations:
  - MOVZ hw0, shamt 0;
  - then MOVK hw1, hw2, hw3 (shamt 1 to 3), including zero halfwords;
  - out_last only on shamt 3.
- The interface and timing rules are identical in both builds.

## Structure
- Shared package mov_seq_pkg contains:
  - the state enum (IDLE, EMIT);
  - constants MOV_TYPE_MOVK=1'b0 and MOV_TYPE_MOVZ=1'b1, which match the MOVZ/MOVK calculator's encoding;
  - the packed struct mov_op_t {rd[4:0], imm16[15:0], shamt[1:0], mov_type, last}.
- Sub-module mov_hw_pick is a combinational lowest-set-bit picker. It maps the 4-bit mask to a 2-bit index, a one-hot clear vector and a single-bit flag.

## Test plan
- Value 0x0000_0000_0000_0000, rd=3 → one operation: rd=3, MOVZ, imm 0x0000, shamt 0, last=1. in_ready returns to 1 on the next cycle.
- Value 0x1234_0000_0000_5678, rd=7 → two operations, in order:
  - MOVZ 0x5678, shamt 0, last=0;
  - MOVK 0x1234, shamt 3, last=1.
- Value 0x0000_BEEF_0000_0000 → one operation: MOVZ 0xBEEF, shamt 2, last=1.
- Value 0xFFFF_FFFF_FFFF_FFFF with out_ready low for 3 cycles before each handshake → four operations:
  - MOVZ shamt 0, then MOVK shamt 1, 2, 3, all with imm 0xFFFF;
  - outputs stable during each stall;
  - in_ready=0 throughout.
- Command 0xAAAA_BBBB_CCCC_DDDD with reset_n asserted after the 2nd handshake → all outputs 0 immediately. After release: in_ready=1, out_valid=0, and the remaining operations are never emitted.
- MOVSEQ_ZERO_SKIP_EN undefined, value 0x1234_0000_0000_5678 → four operations:
  - MOVZ 0x5678 shamt 0;
  - MOVK 0x0000 shamt 1;
  - MOVK 0x0000 shamt 2;
  - MOVK 0x1234 shamt 3, last=1.
